// File: rtl/arith_mult_cst_solinas_stream.sv
// Streaming multiply by the constant 2^E0 + 2^E1 - 2^E2 using only shifts, adds and a subtract.
// Three registered stages with a per-stage valid flag and a ready chain, so empty stages always refill.
module arith_mult_cst_solinas_stream #(
   parameter int IN_W    = 64,
   parameter int LANE_NB = 2,
   parameter int E0      = 96,
   parameter int E1      = 64,
   parameter int E2      = 1,
   parameter int SIDE_W  = 8,
   parameter logic [SIDE_W-1:0] RST_SIDE = '0,
   localparam int Z_W    = IN_W + E0 + 1
) (
   input  logic                     clk,
   input  logic                     a_rst,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [LANE_NB*IN_W-1:0]  in_a,
   input  logic [SIDE_W-1:0]        in_side,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [LANE_NB*Z_W-1:0]   out_z,
   output logic [SIDE_W-1:0]        out_side
);

   if (!(E0 > E1 && E1 > E2 && E2 >= 0)) begin : g_badCst
      $fatal(1, "arith_mult_cst_solinas_stream: exponents must satisfy E0 > E1 > E2 >= 0");
   end

   logic                    r_v0;
   logic                    r_v1;
   logic                    r_v2;
   logic [LANE_NB*IN_W-1:0] r_a0;
   logic [SIDE_W-1:0]       r_side0;
   logic [LANE_NB*Z_W-1:0]  r_p1;
   logic [LANE_NB*Z_W-1:0]  r_n1;
   logic [SIDE_W-1:0]       r_side1;
   logic [LANE_NB*Z_W-1:0]  r_z2;
   logic [SIDE_W-1:0]       r_side2;

   logic                    w_rdy0;
   logic                    w_rdy1;
   logic                    w_rdy2;
   logic [LANE_NB*Z_W-1:0]  w_p;
   logic [LANE_NB*Z_W-1:0]  w_n;
   logic [LANE_NB*Z_W-1:0]  w_d;

   // A stage may take new data if it is empty or its content moves on this edge.
   assign w_rdy2 = !r_v2 || out_rdy;
   assign w_rdy1 = !r_v1 || w_rdy2;
   assign w_rdy0 = !r_v0 || w_rdy1;
   assign in_rdy = w_rdy0 && !a_rst;

   for (genvar g = 0; g < LANE_NB; g++) begin : g_lane
      logic [Z_W-1:0] w_aExt;
      assign w_aExt = Z_W'(r_a0[g*IN_W +: IN_W]);
      assign w_p[g*Z_W +: Z_W] = (w_aExt << E0) + (w_aExt << E1);
      assign w_n[g*Z_W +: Z_W] = w_aExt << E2;
      // P always exceeds N because the constant is positive, so the difference never wraps.
      assign w_d[g*Z_W +: Z_W] = r_p1[g*Z_W +: Z_W] - r_n1[g*Z_W +: Z_W];
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         if (w_rdy0) r_v0 <= in_vld;
         if (w_rdy1) r_v1 <= r_v0;
         if (w_rdy2) r_v2 <= r_v1;
      end
   end

   // Data registers only move when real data enters the stage, never on bubbles.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_a0    <= '0;
         r_side0 <= RST_SIDE;
         r_p1    <= '0;
         r_n1    <= '0;
         r_side1 <= RST_SIDE;
         r_z2    <= '0;
         r_side2 <= RST_SIDE;
      end else begin
         if (in_rdy && in_vld) begin
            r_a0    <= in_a;
            r_side0 <= in_side;
         end
         if (w_rdy1 && r_v0) begin
            r_p1    <= w_p;
            r_n1    <= w_n;
            r_side1 <= r_side0;
         end
         if (w_rdy2 && r_v1) begin
            r_z2    <= w_d;
            r_side2 <= r_side1;
         end
      end
   end

   assign out_vld  = r_v2;
   assign out_z    = r_z2;
   assign out_side = r_side2;

endmodule
